// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file with busy-bit scoreboard.
package regfile_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int REG_ZERO       = 0;
  localparam int REG_A0         = 10;
  localparam int NUM_RD_MAX     = 4;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between decode/issue/writeback (master) and the register file (slave).
interface regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
);

  logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data [NUM_RD];
  logic [NUM_RD-1:0]     rd_ready;
  logic                  iss_en;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic                  iss_stall;
  logic                  wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_spurious;
  logic [DATA_WIDTH-1:0] a0;

  modport master (
    output rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data,
    input  rd_data, rd_ready, iss_stall, wb_spurious, a0
  );

  modport slave (
    input  rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data,
    output rd_data, rd_ready, iss_stall, wb_spurious, a0
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, WAW issue stall and
// the spurious-writeback pulse.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_en_i,
  input  logic [ADDR_WIDTH-1:0]      iss_addr_i,
  input  logic                       wb_en_i,
  input  logic [ADDR_WIDTH-1:0]      wb_addr_i,
  output logic [2**ADDR_WIDTH-1:0]   busy_o,
  output logic                       iss_stall_o,
  output logic                       wb_spurious_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
  logic                     spur_q, spur_d;
  logic                     wbValid;

  assign wbValid     = wb_en_i && (wb_addr_i != ZERO_IDX);
  assign iss_stall_o = iss_en_i && busy_q[iss_addr_i] &&
                       !(wb_en_i && (wb_addr_i == iss_addr_i));

  // Clear on writeback first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wbValid)
      busy_d[wb_addr_i] = 1'b0;
    if (iss_en_i && !iss_stall_o && (iss_addr_i != ZERO_IDX))
      busy_d[iss_addr_i] = 1'b1;
    spur_d = wbValid && !busy_q[wb_addr_i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      spur_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      spur_q <= spur_d;
    end
  end

  assign busy_o        = busy_q;
  assign wb_spurious_o = spur_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD combinational read ports, one writeback port and a
// busy-bit scoreboard. Define REGFILE_BYPASS_EN for write-through bypass.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int DBG_REG    = REG_A0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int                    DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] DBG_IDX  = ADDR_WIDTH'(DBG_REG);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic                  spurious;
  logic                  stall;

  // The debug mirror is an extra read port at index NUM_RD.
  logic [ADDR_WIDTH-1:0] portAddr  [NUM_RD+1];
  logic [DATA_WIDTH-1:0] portData  [NUM_RD+1];
  logic [NUM_RD:0]       portReady;
  logic [NUM_RD:0]       bypassHit;

  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .iss_en_i      (bus.iss_en),
    .iss_addr_i    (bus.iss_addr),
    .wb_en_i       (bus.wb_en),
    .wb_addr_i     (bus.wb_addr),
    .busy_o        (busy),
    .iss_stall_o   (stall),
    .wb_spurious_o (spurious)
  );

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_addr != ZERO_IDX))
      regs_d[bus.wb_addr] = bus.wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs_q <= '{default: '0};
    else
      regs_q <= regs_d;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++)
      portAddr[i] = bus.rd_addr[i];
    portAddr[NUM_RD] = DBG_IDX;
  end

  always_comb begin
    for (int i = 0; i <= NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
      bypassHit[i] = bus.wb_en && (bus.wb_addr == portAddr[i]) &&
                     (bus.wb_addr != ZERO_IDX);
`else
      bypassHit[i] = 1'b0;
`endif
      if (portAddr[i] == ZERO_IDX)
        portData[i] = '0;
      else if (bypassHit[i])
        portData[i] = bus.wb_data;
      else
        portData[i] = regs_q[portAddr[i]];
      portReady[i] = (portAddr[i] == ZERO_IDX) || !busy[portAddr[i]] || bypassHit[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i]  = portData[i];
      bus.rd_ready[i] = portReady[i];
    end
  end

  assign bus.a0          = portData[NUM_RD];
  assign bus.iss_stall   = stall;
  assign bus.wb_spurious = spurious;

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven scoreboard bench for regfile_sb; expectations adapt to
// whether REGFILE_BYPASS_EN is defined.
module tb_regfile_sb;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    bit          rst;
    bit          issEn;
    reg_idx_t    issAddr;
    bit          wbEn;
    reg_idx_t    wbAddr;
    logic [31:0] wbData;
    reg_idx_t    rd0;
    reg_idx_t    rd1;
    logic [31:0] expD0;
    bit          expR0;
    logic [31:0] expD1;
    bit          expR1;
    bit          expStall;
    bit          expSpur;
    logic [31:0] expA0;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t expQ [$];
  vec_t vecs [$];

  regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) bus ();

  regfile_sb #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .NUM_RD    (2),
    .DBG_REG   (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(string name, bit r, bit ie, int ia, bit we, int wa,
                                 logic [31:0] wd, int r0, int r1,
                                 logic [31:0] d0, bit q0, logic [31:0] d1, bit q1,
                                 bit st, bit sp, logic [31:0] a0);
    vec_t v;
    v.name = name; v.rst = r; v.issEn = ie; v.issAddr = reg_idx_t'(ia);
    v.wbEn = we; v.wbAddr = reg_idx_t'(wa); v.wbData = wd;
    v.rd0 = reg_idx_t'(r0); v.rd1 = reg_idx_t'(r1);
    v.expD0 = d0; v.expR0 = q0; v.expD1 = d1; v.expR1 = q1;
    v.expStall = st; v.expSpur = sp; v.expA0 = a0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    bus.iss_en      = v.issEn;
    bus.iss_addr    = v.issAddr;
    bus.wb_en       = v.wbEn;
    bus.wb_addr     = v.wbAddr;
    bus.wb_data     = v.wbData;
    bus.rd_addr[0]  = v.rd0;
    bus.rd_addr[1]  = v.rd1;
    expQ.push_back(v);
  endtask

  task automatic checkField(input string vname, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", vname, field, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t v;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    v = expQ.pop_front();
    checkField(v.name, "rd_data0",  bus.rd_data[0],          v.expD0);
    checkField(v.name, "rd_ready0", 32'(bus.rd_ready[0]),    32'(v.expR0));
    checkField(v.name, "rd_data1",  bus.rd_data[1],          v.expD1);
    checkField(v.name, "rd_ready1", 32'(bus.rd_ready[1]),    32'(v.expR1));
    checkField(v.name, "iss_stall", 32'(bus.iss_stall),      32'(v.expStall));
    checkField(v.name, "spurious",  32'(bus.wb_spurious),    32'(v.expSpur));
    checkField(v.name, "a0",        bus.a0,                  v.expA0);
  endtask

  task automatic runVec(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [31:0] wdat [4];
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.rd_addr[0] = '0; bus.rd_addr[1] = '0;

    //                name          rst ie ia we wa wdata         r0 r1  expD0                         R0    expD1                         R1   st sp a0
    vecs.push_back(mkVec("reset",      1, 0, 0, 0, 0, 32'h0,        5, 10, 32'h0,                        1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("wb_x5",      0, 0, 0, 1, 5, 32'hDEADBEEF, 6, 0,  32'h0,                        1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("rd_x5",      0, 0, 0, 1, 0, 32'h1234,     5, 0,  32'hDEADBEEF,                 1,    32'h0,                        1,    0, 1, 32'h0));
    vecs.push_back(mkVec("rd_x0",      0, 1, 7, 0, 0, 32'h0,        0, 5,  32'h0,                        1,    32'hDEADBEEF,                 1,    0, 0, 32'h0));
    vecs.push_back(mkVec("x7_waw",     0, 1, 7, 0, 0, 32'h0,        7, 5,  32'h0,                        0,    32'hDEADBEEF,                 1,    1, 0, 32'h0));
    vecs.push_back(mkVec("wb_x7_byp",  0, 0, 0, 1, 7, 32'hA5A5A5A5, 5, 7,  32'hDEADBEEF,                 1,    BYP ? 32'hA5A5A5A5 : 32'h0,   BYP,  0, 0, 32'h0));
    vecs.push_back(mkVec("rd_x7",      0, 0, 0, 0, 0, 32'h0,        7, 0,  32'hA5A5A5A5,                 1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("iss_x9",     0, 1, 9, 0, 0, 32'h0,        9, 0,  32'h0,                        1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("iss_wb_x9",  0, 1, 9, 1, 9, 32'h99,       9, 5,  BYP ? 32'h99 : 32'h0,         BYP,  32'hDEADBEEF,                 1,    0, 0, 32'h0));
    vecs.push_back(mkVec("x9_busy",    0, 0, 0, 1, 3, 32'h33,       9, 3,  32'h99,                       0,    BYP ? 32'h33 : 32'h0,         1,    0, 0, 32'h0));
    vecs.push_back(mkVec("spur_x3",    0, 0, 0, 1, 10, 32'hA0A0,    3, 10, 32'h33,                       1,    BYP ? 32'hA0A0 : 32'h0,       1,    0, 1, BYP ? 32'hA0A0 : 32'h0));
    vecs.push_back(mkVec("a0_mirror",  0, 1, 4, 0, 0, 32'h0,        10, 0, 32'hA0A0,                     1,    32'h0,                        1,    0, 1, 32'hA0A0));
    vecs.push_back(mkVec("x4_busy",    0, 0, 0, 0, 0, 32'h0,        4, 10, 32'h0,                        0,    32'hA0A0,                     1,    0, 0, 32'hA0A0));
    vecs.push_back(mkVec("rst_mid",    1, 0, 0, 0, 0, 32'h0,        4, 10, 32'h0,                        1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("wb_x4",      0, 0, 0, 1, 4, 32'h44,       4, 9,  BYP ? 32'h44 : 32'h0,         1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("spur_x4",    0, 0, 0, 0, 0, 32'h0,        4, 0,  32'h44,                       1,    32'h0,                        1,    0, 1, 32'h0));
    vecs.push_back(mkVec("iss_x0",     0, 1, 0, 0, 0, 32'h0,        0, 0,  32'h0,                        1,    32'h0,                        1,    0, 0, 32'h0));
    vecs.push_back(mkVec("x0_idle",    0, 1, 0, 0, 0, 32'h0,        0, 4,  32'h0,                        1,    32'h44,                       1,    0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++)
      runVec(vecs[i]);

    // Back-to-back writes to idle registers, each read back one cycle later.
    for (int k = 0; k < 4; k++)
      wdat[k] = $urandom;
    for (int k = 0; k < 4; k++)
      runVec(mkVec("seq_wr", 0, 0, 0, 1, 12 + k, wdat[k],
                   (k > 0) ? 12 + k - 1 : 0, 10,
                   (k > 0) ? wdat[(k > 0) ? k - 1 : 0] : 32'h0, 1,
                   32'h0, 1, 0, (k > 0), 32'h0));
    runVec(mkVec("seq_rd", 0, 0, 0, 0, 0, 32'h0, 15, 12,
                 wdat[3], 1, wdat[0], 1, 0, 1, 32'h0));

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with integrated busy-bit scoreboard for the pipelined core. It provides NUM_RD combinational read ports and one registered writeback port, and tracks in-flight destination registers from issue to writeback. It reports per-read-port operand readiness and an issue stall for WAW hazards. It sits between decode/issue (read, issue) and the writeback stage, replacing the single-cycle register file.

## Interface
- ADDR_WIDTH, default 5: register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, default 32: register width.
- NUM_RD, default 2: number of read ports, 1..4.
- DBG_REG, default 10: index mirrored on `a0`.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr  in  NUM_RD x ADDR_WIDTH  read indices.
- rd_data  out  NUM_RD x DATA_WIDTH  read data.
- rd_ready  out  NUM_RD  operand not pending.
- iss_en  in  1  issue request: mark iss_addr busy.
- iss_addr  in  ADDR_WIDTH  destination of issuing instruction.
- iss_stall  out  1  issue refused this cycle (combinational).
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_WIDTH  writeback index.
- wb_data  in  DATA_WIDTH  writeback data.
- wb_spurious  out  1  registered pulse: last-cycle writeback hit a non-busy register.
- a0  out  DATA_WIDTH  debug mirror of register DBG_REG.

## Operation
- Register 0 reads 0, is never busy, ignores writes; iss_addr=0 is accepted and sets nothing.
- Write: on posedge with wb_en and wb_addr≠0, reg[wb_addr] <= wb_data; busy[wb_addr] <= 0.
- Issue: iss_stall = iss_en & busy[iss_addr] & ¬(wb_en & wb_addr==iss_addr). When iss_en & ¬iss_stall & iss_addr≠0, busy[iss_addr] <= 1.
- Same-cycle issue and writeback to the same non-zero register: the write happens and busy ends at 1 (issue wins).
- rd_ready[i] = ¬busy[rd_addr[i]] | (bypass hit on port i); always 1 for index 0.
- wb_spurious <= wb_en & wb_addr≠0 & ¬busy[wb_addr]. The register write still occurs.
- a0 follows the same read path as a read port addressed at DBG_REG, including bypass.

## Timing
- Reads: combinational, zero latency. Writeback is visible via the array from the cycle after wb_en.
- Issue-to-busy latency is 1 cycle. iss_stall and rd_ready are combinational on current inputs and state.
- Reset (async assert, synchronous-safe deassert handled upstream):
  - all registers = 0 and all busy = 0;
  - hence rd_data = 0, rd_ready = all 1, iss_stall = 0, wb_spurious = 0, a0 = 0.
- Reset mid-operation: pending busy bits are discarded. A later writeback to such a register raises wb_spurious.

## Configuration
- REGFILE_BYPASS_EN defined: write-through bypass is compiled in.
  - When wb_en & wb_addr==rd_addr[i] & wb_addr≠0, rd_data[i] = wb_data and rd_ready[i] = 1 in the same cycle.
- REGFILE_BYPASS_EN undefined: no bypass.
  - rd_data returns the stored value in the writeback cycle.
  - rd_ready[i] = ¬busy[rd_addr[i]], so it is 0 until the cycle after writeback.

## Structure
- Package regfile_pkg holds:
  - typedef reg_idx_t (logic [ADDR_WIDTH-1:0] for default width);
  - constants REG_ZERO = 0 and REG_A0 = 10;
  - NUM_RD_MAX = 4.
- Sub-module regfile_scoreboard owns the busy vector, issue/stall logic and wb_spurious.
  - The top holds the data array, read muxes and bypass.

## Test plan
- Reset then read: assert rst, read x5/x10 -> rd_data 0, rd_ready 1, a0 0.
- Write/read: wb x5=0xDEADBEEF; next cycle rd_addr[0]=5 -> 0xDEADBEEF. Write x0=0x1234 -> x0 still reads 0.
- Scoreboard: issue x7 -> next cycle rd_ready 0 on port reading x7; re-issue x7 -> iss_stall 1. wb x7=0x55 -> rd_ready 1 and the value reads 0x55.
- Bypass (REGFILE_BYPASS_EN): x7 busy, wb x7=0xA5A5A5A5 with rd_addr[1]=7 in the same cycle -> rd_data[1]=0xA5A5A5A5 and rd_ready[1]=1 that cycle. Without the macro -> old value and rd_ready 0.
- Simultaneous issue+wb on x9 while busy -> iss_stall 0, x9 written, busy[9] stays 1. wb to idle x3 -> wb_spurious 1 next cycle.
- Reset mid-flight: issue x4, assert rst -> rd_ready 1 and data 0. Then wb x4 -> wb_spurious 1.
